cla_share_ctrl: RTL and testbench
=================================

# cla_share_ctrl

Sequencing controller that time-shares one 16-bit carry-lookahead add/subtract unit (`CLA_16bit_top`: A, B, mode in; S, Cout, Ovf out) between two requesters. Each requester issues operations over a valid/ready handshake. The block arbitrates round-robin, registers operands, runs one datapath cycle and holds a registered result until the consumer accepts it. It sits between the lab's operand sources and a single result sink.

## Interface
- `WIDTH`, 16: operand/result width; fixed by the datapath, other values unsupported.
- `CNT_W`, 8: width of the completed-operation counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  per-requester operation valid.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_a`  in  2×WIDTH  operand A, requester i in bits [i*16 +: 16].
- `req_b`  in  2×WIDTH  operand B, same packing.
- `req_mode`  in  2  0 = A+B, 1 = A−B, per requester.
- `rsp_valid`  out  1  result held valid.
- `rsp_ready`  in  1  sink accepts result.
- `rsp_id`  out  1  requester that issued the held result.
- `rsp_s`  out  WIDTH  sum/difference.
- `rsp_cout`  out  1  carry out of bit 15 of A + (B ^ {16{mode}}) + mode.
- `rsp_ovf`  out  1  two's-complement overflow.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  CNT_W  count of results accepted by the sink; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `req_ready[g]` = 1 only for the granted requester g. The grant is computed combinationally from `req_valid` and the round-robin pointer `rr_ptr`.
  - If only one requester is valid, it is granted.
  - If both are valid, `rr_ptr` is granted.
  - On handshake (`req_valid[g] & req_ready[g]`): latch the A, B and mode operands, latch id = g, set `rr_ptr` to the other requester (~g), then go to EXEC.
- EXEC: the latched operands drive the datapath. At the clock edge, capture S, Cout and Ovf into the response registers, then go to DONE. `req_ready` = 0.
- DONE: `rsp_valid` = 1; the response outputs are stable. On `rsp_ready`, increment `ops_done` and go to IDLE. `req_ready` = 0 in DONE and EXEC.
- Subtraction flags:
  - `rsp_cout` = 1 means no borrow (A ≥ B unsigned).
  - `rsp_ovf` = (A15 == B'15) & (S15 != A15), where B' = B ^ {16{mode}}.
- Non-granted valid requests wait. Requesters must hold their payload stable until accepted. A requester may drop `req_valid` before acceptance without side effects.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - state = IDLE, `rr_ptr` = 0.
  - `req_ready` = 0 during reset; IDLE grant logic applies immediately after.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_s` = 0, `rsp_cout` = 0, `rsp_ovf` = 0, `busy` = 0, `ops_done` = 0.
- Latency: accept at edge N → EXEC during cycle N+1 → `rsp_valid` = 1 from cycle N+2.
- Throughput: at most one operation per 3 cycles (when `rsp_ready` is tied high).
- `rsp_ready` high in the first DONE cycle means the FSM is back in IDLE in the next cycle. A new request is accepted no earlier than that IDLE cycle.
- `rsp_ready` asserted outside DONE is ignored.
- `ops_done` wraps from 2^CNT_W−1 to 0 with no flag.
- Reset mid-operation: the in-flight operation is discarded with no response, and all outputs return to their reset values.

## Structure
- Package `cla_ctrl_pkg` holds:
  - the state enum (IDLE/EXEC/DONE);
  - `CLA_W` = 16;
  - `NREQ` = 2;
  - the requester id type.
- Sub-module `cla_rr_arb` (2-way round-robin grant: inputs valid and ptr, output one-hot grant).
- The top instantiates one `CLA_16bit_top` as the datapath. No arithmetic is duplicated in the controller.

## Test plan
- Req0 only, A=25, B=10, mode=0 → after 2 cycles `rsp_s`=35, cout=0, ovf=0, id=0; `ops_done`=1 after accept.
- Req1, A=32767, B=2, add → `rsp_s`=0x8001, cout=0, ovf=1. Also A=32000, B=16000, add → 0xBB80, cout=0, ovf=1.
- Subtract: A=40, B=10 → 30, cout=1, ovf=0. A=10, B=20 → 0xFFF6, cout=0, ovf=0. A=500, B=100 → 400, cout=1.
- Both requesters valid continuously, `rsp_ready`=1 → grants alternate 0,1,0,1; a new accept every 3 cycles; `req_ready` is never high for both requesters.
- `rsp_ready` held low 5 cycles in DONE → outputs stable, no `req_ready`, `busy`=1; release → IDLE the next cycle and `ops_done` increments once.
- Assert `rst_n` low during EXEC → all outputs zero immediately, no response, `rr_ptr`=0. A 256-accept run shows `ops_done` wrapping to 0.

Source files
------------

// File: rtl/cla_ctrl_pkg.sv
// Purpose: shared types and helpers for the shared carry-lookahead controller.
//   state_t      : controller sequencing states
//   req_id_t     : requester index
//   op_t         : latched operand payload (A, B, mode)
//   cla4_carries : 4-bit lookahead carry expansion, used at bit and group level
package cla_ctrl_pkg;

    localparam int unsigned CLA_W = 16;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned ID_W  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic [CLA_W-1:0] a;
        logic [CLA_W-1:0] b;
        logic             mode;
    } op_t;

    // Carries c[0..4] of a 4-wide generate/propagate slice, fully expanded.
    function automatic logic [4:0] cla4_carries(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & ci);
        return c;
    endfunction

endpackage

// File: rtl/CLA_16bit_top.sv
// Purpose: 16-bit two-level carry-lookahead adder/subtractor.
//   A, B : operands
//   mode : 0 = A+B, 1 = A-B (B inverted, carry-in = 1)
//   S    : sum/difference
//   Cout : carry out of bit 15 (1 = no borrow when subtracting)
//   Ovf  : two's-complement overflow
module CLA_16bit_top
    import cla_ctrl_pkg::*;
(
    input  logic [CLA_W-1:0] A,
    input  logic [CLA_W-1:0] B,
    input  logic             mode,
    output logic [CLA_W-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned NGRP = CLA_W / 4;

    logic [CLA_W-1:0] bx;
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W-1:0] c;
    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gp;
    logic [NGRP:0]    gc;
    logic [4:0]       t;

    // Group generate/propagate, then group carries, then in-group bit carries.
    always_comb begin
        bx = B ^ {CLA_W{mode}};
        g  = A & bx;
        p  = A ^ bx;
        t  = '0;
        for (int k = 0; k < NGRP; k++) begin
            t     = cla4_carries(g[k*4 +: 4], p[k*4 +: 4], 1'b0);
            gg[k] = t[4];
            gp[k] = &p[k*4 +: 4];
        end
        gc = cla4_carries(gg, gp, mode);
        for (int k = 0; k < NGRP; k++) begin
            t            = cla4_carries(g[k*4 +: 4], p[k*4 +: 4], gc[k]);
            c[k*4 +: 4]  = t[3:0];
        end
        S    = p ^ c;
        Cout = gc[NGRP];
        Ovf  = (A[CLA_W-1] == bx[CLA_W-1]) & (S[CLA_W-1] != A[CLA_W-1]);
    end

endmodule

// File: rtl/cla_rr_arb.sv
// Purpose: 2-way round-robin grant. A lone valid requester always wins; when
// both are valid the pointer selects the winner.
//   valid   : per-requester request
//   ptr     : requester favoured on a tie
//   grant_c : one-hot (or zero) combinational grant
module cla_rr_arb
    import cla_ctrl_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  req_id_t         ptr,
    output logic [NREQ-1:0] grant_c
);

    always_comb begin
        grant_c = '0;
        if (&valid) begin
            grant_c[ptr] = 1'b1;
        end else begin
            grant_c = valid;
        end
    end

endmodule

// File: rtl/cla_share_ctrl.sv
// Purpose: time-shares one CLA add/subtract unit between two requesters.
// Round-robin accept in IDLE, one datapath cycle in EXEC, result held in DONE
// until the sink accepts.
//   req_valid/req_ready : per-requester handshake (ready is combinational in IDLE)
//   req_a/req_b/req_mode: per-requester payload, requester i in [i*WIDTH +: WIDTH]
//   rsp_*               : registered result, id and flags, held while rsp_valid
//   busy                : controller not in IDLE
//   ops_done            : results accepted by the sink, wrapping
module cla_share_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_s,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic                  busy,
    output logic [CNT_W-1:0]      ops_done
);

    state_t           state_q, state_d;
    req_id_t          rr_q, rr_d;
    req_id_t          id_q, id_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]  grant_c;
    req_id_t          gid_c;
    logic             hs_c;
    logic [WIDTH-1:0] dp_s;
    logic             dp_cout;
    logic             dp_ovf;

    cla_rr_arb u_arb (
        .valid   (req_valid),
        .ptr     (rr_q),
        .grant_c (grant_c)
    );

    CLA_16bit_top u_cla (
        .A    (op_q.a),
        .B    (op_q.b),
        .mode (op_q.mode),
        .S    (dp_s),
        .Cout (dp_cout),
        .Ovf  (dp_ovf)
    );

    // Grant is only offered in IDLE and never while reset is asserted.
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant_c : '0;
    assign gid_c     = grant_c[1];
    assign hs_c      = |(req_valid & req_ready);

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        op_d    = op_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs_c) begin
                    op_d.a    = gid_c ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    op_d.b    = gid_c ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    op_d.mode = req_mode[gid_c];
                    id_d      = gid_c;
                    rr_d      = ~gid_c;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                s_d     = dp_s;
                cout_d  = dp_cout;
                ovf_d   = dp_ovf;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            op_q    <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_s     = s_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;
    assign ops_done  = cnt_q;

endmodule

// File: tb/tb_cla_share_ctrl.sv
// Scoreboard bench for cla_share_ctrl: handshakes push the reference result,
// the monitor pops and compares when the result is presented.
module tb_cla_share_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*W-1:0]  req_a;
    logic [2*W-1:0]  req_b;
    logic [1:0]      req_mode;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [W-1:0]    rsp_s;
    logic            rsp_cout;
    logic            rsp_ovf;
    logic            busy;
    logic [CW-1:0]   ops_done;

    always #5 clk = ~clk;

    cla_share_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    typedef struct packed {
        logic         id;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            cyc       = 0;
    bit            pend      = 1'b0;
    int            hs_cyc    = 0;
    logic          exp_ptr   = 1'b0;
    logic [CW-1:0] exp_ops   = '0;
    int            hs_count  = 0;
    int            rsp_cnt   = 0;
    logic [1:0]    hs_mask   = 2'b00;
    bit            b2b_mode  = 1'b0;
    int            last_hs   = 0;
    bit            last_hs_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic reference: plain signed/unsigned integer maths.
    function automatic exp_t ref_op(input logic id, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic m);
        exp_t e;
        int   sa, sb, ua, ub, r;
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        ua     = int'(a);
        ub     = int'(b);
        r      = m ? (sa - sb) : (sa + sb);
        e.id   = id;
        e.s    = 16'(r);
        e.ovf  = (r > 32767) || (r < -32768);
        e.cout = m ? (ua >= ub) : ((ua + ub) > 65535);
        return e;
    endfunction

    // Round-robin rule: lone requester wins, tie goes to the pointer.
    function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic ptr);
        if (v == 2'b11) return ptr ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard.
    initial begin
        logic [1:0] er;
        logic [1:0] hs;
        logic       exp_valid;
        logic       id;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                er        = pend ? 2'b00 : ref_grant(req_valid, exp_ptr);
                exp_valid = pend && (cyc >= hs_cyc + 2);
                chk("req_ready", 32'(req_ready), 32'(er));
                chk("busy", 32'(busy), 32'(pend));
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
                chk("ops_done", 32'(ops_done), 32'(exp_ops));
                if (exp_valid) begin
                    if (sb_q.size() == 0) begin
                        fail_now("scoreboard_empty");
                    end else begin
                        e = sb_q[0];
                        chk("rsp_s", 32'(rsp_s), 32'(e.s));
                        chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                        if (rsp_ready) begin
                            void'(sb_q.pop_front());
                            exp_ops = exp_ops + 1'b1;
                            pend    = 1'b0;
                            rsp_cnt++;
                        end
                    end
                end else begin
                    hs = req_valid & req_ready;
                    if (hs != 2'b00 && !pend) begin
                        id = hs[1];
                        sb_q.push_back(ref_op(id,
                                              id ? req_a[2*W-1:W] : req_a[W-1:0],
                                              id ? req_b[2*W-1:W] : req_b[W-1:0],
                                              req_mode[id]));
                        if (b2b_mode && last_hs_ok) chk("accept_spacing", 32'(cyc - last_hs), 32'd3);
                        last_hs    = cyc;
                        last_hs_ok = 1'b1;
                        pend       = 1'b1;
                        hs_cyc     = cyc;
                        exp_ptr    = ~id;
                        hs_mask    = hs;
                        hs_count++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_payload(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic m);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_mode[r]     = m;
    endtask

    task automatic rand_payload(input int r);
        set_payload(r, pick16(), pick16(), 1'($urandom_range(0, 1)));
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int t;
        t = 0;
        while (rsp_cnt < target && t < budget) begin
            step();
            t++;
        end
        if (rsp_cnt < target) fail_now(name);
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int t;
        t = 0;
        while (hs_count < target && t < budget) begin
            step();
            t++;
        end
        if (hs_count < target) fail_now(name);
    endtask

    task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m);
        int h0, r0;
        h0 = hs_count;
        r0 = rsp_cnt;
        set_payload(r, a, b, m);
        req_valid[r] = 1'b1;
        wait_hs(h0 + 1, 20, "issue_accept");
        req_valid[r] = 1'b0;
        wait_rsp(r0 + 1, 20, "issue_response");
    endtask

    task automatic run_b2b(input int n);
        int h0, r0, seen, t;
        h0         = hs_count;
        r0         = rsp_cnt;
        seen       = h0;
        t          = 0;
        rsp_ready  = 1'b1;
        rand_payload(0);
        rand_payload(1);
        req_valid  = 2'b11;
        last_hs_ok = 1'b0;
        b2b_mode   = 1'b1;
        while (hs_count < h0 + n && t < n * 3 + 20) begin
            step();
            t++;
            if (hs_count != seen) begin
                seen = hs_count;
                rand_payload(hs_mask[1] ? 1 : 0);
            end
        end
        if (hs_count < h0 + n) fail_now("b2b_accepts");
        req_valid = 2'b00;
        wait_rsp(r0 + n, 20, "b2b_response");
        b2b_mode = 1'b0;
    endtask

    task automatic run_random(input int ncyc);
        int  seen;
        seen = hs_count;
        for (int i = 0; i < ncyc; i++) begin
            step();
            for (int r = 0; r < 2; r++) begin
                if (hs_count != seen && hs_mask[r]) begin
                    if ($urandom_range(0, 1) == 1) rand_payload(r);
                    else req_valid[r] = 1'b0;
                end else if (!req_valid[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_payload(r);
                        req_valid[r] = 1'b1;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            seen      = hs_count;
            rsp_ready = 1'($urandom_range(0, 1));
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && pend; i++) step();
        if (pend) fail_now("random_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, r0, r_base;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = {16'h1111, 16'h2222};
        req_b     = {16'h3333, 16'h4444};
        req_mode  = 2'b00;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_s", 32'(rsp_s), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        step();

        // Directed arithmetic cases, including overflow and borrow corners.
        issue(0, 16'd25, 16'd10, 1'b0);
        chk("ops_after_first", 32'(ops_done), 32'd1);
        issue(1, 16'd32767, 16'd2, 1'b0);
        issue(1, 16'd32000, 16'd16000, 1'b0);
        issue(0, 16'd40, 16'd10, 1'b1);
        issue(1, 16'd10, 16'd20, 1'b1);
        issue(0, 16'd500, 16'd100, 1'b1);

        // Both requesters continuously valid: alternating grants, 3-cycle spacing.
        run_b2b(20);

        // Sink stalls for 5 DONE cycles while the other requester waits.
        rsp_ready = 1'b0;
        h0 = hs_count;
        r0 = rsp_cnt;
        set_payload(0, 16'd1234, 16'd4321, 1'b1);
        req_valid = 2'b01;
        wait_hs(h0 + 1, 20, "stall_accept");
        req_valid = 2'b00;
        rand_payload(1);
        req_valid[1] = 1'b1;
        for (int t = 0; t < 10 && !rsp_valid; t++) step();
        repeat (5) step();
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        chk("stall_ops", 32'(ops_done), 32'(8'(r0)));
        rsp_ready = 1'b1;
        wait_hs(h0 + 2, 20, "stall_second_accept");
        req_valid = 2'b00;
        wait_rsp(r0 + 2, 20, "stall_response");

        run_random(300);

        // Reset while requester 0's operation is in EXEC.
        rsp_ready = 1'b1;
        h0 = hs_count;
        rand_payload(0);
        req_valid = 2'b01;
        wait_hs(h0 + 1, 20, "exec_reset_accept");
        chk("exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        pend       = 1'b0;
        exp_ptr    = 1'b0;
        exp_ops    = '0;
        last_hs_ok = 1'b0;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_s", 32'(rsp_s), 32'd0);
        chk("mid_rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("mid_rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_ops_done", 32'(ops_done), 32'd0);
        req_valid = 2'b11;
        step();
        step();
        chk("in_rst_req_ready", 32'(req_ready), 32'd0);
        r_base = rsp_cnt;
        rst_n  = 1'b1;

        // 256 accepted results after reset: counter wraps back to zero.
        run_b2b(256);
        chk("ops_wrap", 32'(ops_done), 32'(8'(rsp_cnt - r_base)));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
